jtcop_prot_bridge: RTL

- Main-CPU-side bridge to the protection MCU's 2 kB shared RAM window; it is the initiator end of the shared-RAM mailbox protocol.
- Converts 68000-style bus cycles into single-cycle accesses on the shared RAM's main port and generates DTACK with a programmable wait.
- Raises the MCU doorbell interrupt when the main CPU writes the last mailbox byte.
- Holds the doorbell until the MCU acknowledges it.

---
 rtl/jtcop_prot_bridge.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/jtcop_prot_bridge.sv
// jtcop_prot_bridge: main-CPU side of the protection MCU shared-RAM mailbox.
// Turns 68000 bus cycles into single-cycle accesses on the RAM main port,
// generates DTACK after a programmable wait, and rings the MCU doorbell when
// the last mailbox byte (0x7ff) is written.
// Optional build macro: JTCOP_BRIDGE_TIMEOUT_EN. It adds a doorbell timeout
// that drops an unacknowledged doorbell after IRQ_TO cycles and sets a sticky
// timeout flag.
module jtcop_prot_bridge #(
    parameter int RD_WAIT   = 1,    // RAM read latency, 1..3
    parameter int DTACK_DLY = 0,    // extra cycles before DTACK, 0..7
    parameter int IRQ_TO    = 1023  // doorbell timeout, timeout build only
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        main_cs,
    input  logic        main_rnw,
    input  logic [10:0] main_addr,
    input  logic        main_lds_n,
    input  logic [7:0]  main_dout,
    output logic [15:0] main_din,
    output logic        main_dtackn,
    output logic [10:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_data,
    input  logic [7:0]  ram_q,
    output logic        mcu_irqn,
    input  logic        mcu_ack,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic [2:0] {IDLE, ISSUE, RWAIT, DLY, ACK} state_t;

    localparam logic [1:0]  WAIT_N    = 2'(RD_WAIT);
    localparam logic [2:0]  DLY_N     = 3'(DTACK_DLY);
    localparam logic [10:0] BELL_ADDR = 11'h7ff;

    state_t      state_q, state_d;
    logic        cs_q, cs_d;
    logic        rnw_q, rnw_d;
    logic        lds_n_q, lds_n_d;
    logic [10:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        we_q, we_d;
    logic [1:0]  wcnt_q, wcnt_d;
    logic [2:0]  dcnt_q, dcnt_d;
    logic [7:0]  din_q, din_d;
    logic        dtackn_q, dtackn_d;
    logic        irqn_q, irqn_d;
    logic        busy_q, busy_d;
    logic        ring;

`ifdef JTCOP_BRIDGE_TIMEOUT_EN
    localparam int TW = ($clog2(IRQ_TO + 1) > 10) ? $clog2(IRQ_TO + 1) : 10;
    localparam logic [TW-1:0] TO_LAST = TW'(IRQ_TO - 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tmo_q, tmo_d;
`endif

    // Bus-cycle FSM: start on a registered cs rise, abort whenever cs drops
    // before DTACK, and hold DTACK low until cs is released.
    always_comb begin
        state_d  = state_q;
        cs_d     = main_cs;
        rnw_d    = rnw_q;
        lds_n_d  = lds_n_q;
        addr_d   = addr_q;
        data_d   = data_q;
        we_d     = 1'b0;
        wcnt_d   = wcnt_q;
        dcnt_d   = dcnt_q;
        din_d    = din_q;
        dtackn_d = dtackn_q;
        ring     = 1'b0;
        case (state_q)
            IDLE: begin
                // Outputs are registered, so address and strobe are loaded
                // here and are on the RAM port for the whole ISSUE cycle.
                if (main_cs && !cs_q) begin
                    state_d = ISSUE;
                    rnw_d   = main_rnw;
                    lds_n_d = main_lds_n;
                    addr_d  = main_addr;
                    data_d  = main_dout;
                    we_d    = !main_rnw && !main_lds_n;
                end
            end
            ISSUE: begin
                // The strobe already went out, so the doorbell rings even if
                // the CPU abandons the cycle right here.
                ring   = !rnw_q && !lds_n_q && (addr_q == BELL_ADDR);
                wcnt_d = WAIT_N;
                dcnt_d = 3'd0;
                if (!main_cs)   state_d = IDLE;
                else if (rnw_q) state_d = RWAIT;
                else            state_d = DLY;
            end
            RWAIT: begin
                if (!main_cs) begin
                    state_d = IDLE;
                end else if (wcnt_q == 2'd1) begin
                    din_d   = ram_q;
                    state_d = DLY;
                end else begin
                    wcnt_d = wcnt_q - 2'd1;
                end
            end
            DLY: begin
                if (!main_cs) begin
                    state_d = IDLE;
                end else if (dcnt_q == DLY_N) begin
                    dtackn_d = 1'b0;
                    state_d  = ACK;
                end else begin
                    dcnt_d = dcnt_q + 3'd1;
                end
            end
            ACK: begin
                if (!main_cs) begin
                    dtackn_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Doorbell: a new ring beats a simultaneous ack; re-ringing while pending
    // leaves the line low without a fresh edge.
    always_comb begin
        irqn_d = irqn_q;
`ifdef JTCOP_BRIDGE_TIMEOUT_EN
        tcnt_d = tcnt_q;
        tmo_d  = tmo_q;
        if (ring) begin
            irqn_d = 1'b0;
            tcnt_d = '0;
            tmo_d  = 1'b0;
        end else if (mcu_ack) begin
            irqn_d = 1'b1;
            tcnt_d = '0;
        end else if (!irqn_q) begin
            if (tcnt_q == TO_LAST) begin
                irqn_d = 1'b1;
                tmo_d  = 1'b1;
                tcnt_d = '0;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
`else
        if (ring)         irqn_d = 1'b0;
        else if (mcu_ack) irqn_d = 1'b1;
`endif
        busy_d = ~irqn_d;
    end

    // State and output registers; cs history resets high so a select held
    // across reset is not mistaken for a new cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cs_q     <= 1'b1;
            rnw_q    <= 1'b1;
            lds_n_q  <= 1'b1;
            addr_q   <= 11'd0;
            data_q   <= 8'd0;
            we_q     <= 1'b0;
            wcnt_q   <= 2'd0;
            dcnt_q   <= 3'd0;
            din_q    <= 8'hff;
            dtackn_q <= 1'b1;
            irqn_q   <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cs_q     <= cs_d;
            rnw_q    <= rnw_d;
            lds_n_q  <= lds_n_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_q     <= we_d;
            wcnt_q   <= wcnt_d;
            dcnt_q   <= dcnt_d;
            din_q    <= din_d;
            dtackn_q <= dtackn_d;
            irqn_q   <= irqn_d;
            busy_q   <= busy_d;
        end
    end

`ifdef JTCOP_BRIDGE_TIMEOUT_EN
    // Doorbell timeout counter and sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tmo_q  <= tmo_d;
        end
    end
    assign timeout = tmo_q;
`else
    assign timeout = 1'b0;
`endif

    assign main_din    = {8'hff, din_q};
    assign main_dtackn = dtackn_q;
    assign ram_addr    = addr_q;
    assign ram_we      = we_q;
    assign ram_data    = data_q;
    assign mcu_irqn    = irqn_q;
    assign busy        = busy_q;

endmodule
